// File: rtl/bitwise_logic_accumulator_pkg.sv
// Shared encodings for the bitwise logic accumulator.
//   OP_*  : 2-bit operation select seen on the op port and held in op_q.
//   state_t: frame state (IDLE waiting for first beat, ACCUM folding, HOLD
//            presenting the result until downstream takes it).
package bitwise_logic_accumulator_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_logic_accumulator_logic_op_unit.sv
// Combinational bitwise operator used in the fold path.
//   a  : running accumulator value
//   b  : incoming operand
//   op : operation select; NAND folds as AND (inversion happens at output)
//   y  : a OP b
module logic_op_unit
  import bitwise_logic_accumulator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a & b;
    case (op)
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = a & b;  // AND and NAND share the AND fold
    endcase
  end

endmodule

// File: rtl/bitwise_logic_accumulator.sv
// Folds a stream of WIDTH-bit beats with AND/OR/XOR/NAND into one result per
// frame. A frame ends on in_last or when MAX_LEN beats have been taken.
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   op               : operation, sampled on the first beat of a frame
//   in_valid/in_ready: input handshake; in_data operand, in_last frame end
//   out_valid/out_ready: output handshake
//   out_data         : reduced result (inverted for NAND)
//   out_count        : beats folded into the result
//   out_trunc        : frame closed by MAX_LEN instead of in_last
module bitwise_logic_accumulator
  import bitwise_logic_accumulator_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   op,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(MAX_LEN+1)-1:0] out_count,
  output logic                         out_trunc
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_trunc_q, out_trunc_d;
  logic               in_ready_q, in_ready_d;

  logic               beat;
  logic               close;
  logic [WIDTH-1:0]   fold_y;

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .a  (acc_q),
    .b  (in_data),
    .op (op_q),
    .y  (fold_y)
  );

  assign beat = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;
    close       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (beat) begin
          op_d  = op;
          acc_d = in_data;
          cnt_d = CNT_W'(1);
          if (in_last || (MAX_LEN == 1)) close = 1'b1;
          else state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          acc_d = fold_y;
          cnt_d = cnt_q + CNT_W'(1);
          // cnt_q is the count before this beat, so this beat is the
          // MAX_LEN-th one when cnt_q == MAX_LEN-1.
          if (in_last || (cnt_q == CNT_W'(MAX_LEN - 1))) close = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The closing beat's contribution is already in acc_d/op_d, so the
    // result register captures the complete frame on the same edge.
    if (close) begin
      state_d     = S_HOLD;
      out_valid_d = 1'b1;
      out_data_d  = (op_d == OP_NAND) ? ~acc_d : acc_d;
      out_count_d = cnt_d;
      out_trunc_d = ~in_last;
    end

    // Registered ready keeps in_ready low through reset and lets it rise
    // on the first edge after release.
    in_ready_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_bitwise_logic_accumulator.sv
// Directed bench for bitwise_logic_accumulator with WIDTH=8, MAX_LEN=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bitwise_logic_accumulator;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_trunc;

  int n_compared = 0;
  int n_mismatch = 0;

  bitwise_logic_accumulator #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one beat and returns at the falling
  // edge after the rising edge that accepted it.
  task automatic send(input logic [1:0] o, input logic [7:0] d, input logic last);
    int n = 0;
    op = o; in_data = d; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Checks the result registers at a falling edge while out_valid is high.
  task automatic check_result(input string tag, input logic [7:0] d,
                              input int cnt, input logic trunc);
    $display("frame %s: data=0x%02h count=%0d trunc=%0b", tag, out_data, out_count, out_trunc);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"},  {24'd0, out_data}, {24'd0, d});
    check({tag, "_count"}, {29'd0, out_count}, cnt);
    check({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, trunc});
    check({tag, "_ready_hold"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; op = 2'b00; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data}, 32'd0);
    check("rst_out_count", {29'd0, out_count}, 32'd0);
    check("rst_out_trunc", {31'd0, out_trunc}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // AND frame; op changed to OR after the first beat must be ignored.
    send(2'b00, 8'hFF, 1'b0);
    send(2'b01, 8'hF0, 1'b0);
    check("and_no_early_valid", {31'd0, out_valid}, 32'd0);
    send(2'b01, 8'h3C, 1'b1);
    check_result("and", 8'h30, 3, 1'b0);
    @(negedge clk);
    check("and_xfer_valid", {31'd0, out_valid}, 32'd0);
    check("and_xfer_ready", {31'd0, in_ready}, 32'd1);
    check("and_data_kept",  {24'd0, out_data}, 32'h30);

    // XOR frame with a two-cycle bubble.
    send(2'b10, 8'hA5, 1'b0);
    send(2'b10, 8'h5A, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("xor_bubble_valid", {31'd0, out_valid}, 32'd0);
      check("xor_bubble_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    send(2'b10, 8'hFF, 1'b1);
    check_result("xor", 8'h00, 3, 1'b0);
    @(negedge clk);

    // NAND single beat.
    send(2'b11, 8'h0F, 1'b1);
    check_result("nand", 8'hF0, 1, 1'b0);
    @(negedge clk);

    // OR with forced close at MAX_LEN; next beat waits out the HOLD.
    out_ready = 1'b0;
    send(2'b01, 8'h01, 1'b0);
    send(2'b01, 8'h02, 1'b0);
    send(2'b01, 8'h04, 1'b0);
    send(2'b01, 8'h08, 1'b0);
    check_result("or_trunc", 8'h0F, 4, 1'b1);
    out_ready = 1'b1;
    send(2'b01, 8'h10, 1'b0);
    send(2'b01, 8'h20, 1'b1);
    check_result("or_tail", 8'h30, 2, 1'b0);
    @(negedge clk);

    // in_last exactly on the MAX_LEN-th beat is not a truncation.
    send(2'b00, 8'hFF, 1'b0);
    send(2'b00, 8'hFF, 1'b0);
    send(2'b00, 8'h3F, 1'b0);
    send(2'b00, 8'h1F, 1'b1);
    check_result("and_exact", 8'h1F, 4, 1'b0);
    @(negedge clk);

    // Back-pressure: result held stable for five cycles while op toggles.
    out_ready = 1'b0;
    send(2'b01, 8'h11, 1'b0);
    send(2'b01, 8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      op = op ^ 2'b11;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data",  {24'd0, out_data}, 32'h33);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    $display("frame bp: data=0x%02h count=%0d trunc=%0b", out_data, out_count, out_trunc);
    check("bp_count", {29'd0, out_count}, 32'd2);
    @(negedge clk);
    check("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
    check("bp_xfer_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-frame discards the partial result.
    send(2'b00, 8'h12, 1'b0);
    send(2'b00, 8'h34, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {31'd0, in_ready}, 32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data",  {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(2'b00, 8'h81, 1'b1);
    check_result("post_arst", 8'h81, 1, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
